// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parametrised synchronous FIFO with occupancy count, threshold flags and sticky errors
// Supports registered-read (FWFT=0) or first-word-fall-through (FWFT=1) output.
module param_sync_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 32,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_en,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     read_en,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("param_sync_fifo: DATA_WIDTH must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("param_sync_fifo: AFULL_THRESH out of range");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("param_sync_fifo: AEMPTY_THRESH out of range");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  rd_acc;
  logic                  wr_acc;

  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AFULL_THRESH));
  assign almost_empty = (count_q <= CW'(AEMPTY_THRESH));
  assign count        = count_q;

  // A full FIFO can still take a write when a pop frees a slot in the same cycle.
  assign rd_acc = read_en && !empty;
  assign wr_acc = write_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count_q   <= count_q + CW'(wr_acc) - CW'(rd_acc);
      overflow  <= overflow  | (write_en && !wr_acc);
      underflow <= underflow | (read_en  && !rd_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n && wr_acc) mem[wr_ptr] <= data_in;
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out   = mem[rd_ptr];
    assign data_valid = !empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;

    always_ff @(posedge clk) begin
      if (rst_n) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr];
      end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised synchronous FIFO, the successor to the team's basic FIFO. It adds true DEPTH-entry capacity, an occupancy count, programmable almost-full and almost-empty flags, and sticky overflow/underflow error flags. A build-time mode selects standard registered-read or first-word-fall-through (FWFT) output. It buffers data between producer and consumer stages of the softmax datapath, for example the exp-value buffering between the max pass and the normalisation pass.

Parameters:
DATA_WIDTH, 32, width of each entry in bits (≥1)
DEPTH, 32, number of entries; must be a power of two and ≥2
FWFT, 0, 0 = standard mode (data_out updates one cycle after an accepted read); 1 = first-word-fall-through
AFULL_THRESH, DEPTH-4, almost_full asserts when count ≥ AFULL_THRESH (range 1..DEPTH)
AEMPTY_THRESH, 4, almost_empty asserts when count ≤ AEMPTY_THRESH (range 0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; synchronous, active-high (asserted = 1 despite the suffix)
write_en  in  1  write request
data_in  in  DATA_WIDTH  write data
read_en  in  1  read request (FWFT: pop acknowledge)
data_out  out  DATA_WIDTH  read data
data_valid  out  1  standard mode: one-cycle pulse, data_out holds popped word; FWFT: equals !empty
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count ≥ AFULL_THRESH
almost_empty  out  1  count ≤ AEMPTY_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky; set on a rejected write
underflow  out  1  sticky; set on a rejected read

Behaviour:
- Reset (rst_n=1 at a clk edge): pointers=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0. Therefore empty=1, full=0, almost_empty=1, and almost_full=0 (given AFULL_THRESH ≥ 1). Memory contents are not cleared. Reset overrides any concurrent read or write.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. Occupancy is tracked by count, so all DEPTH entries are usable.
- Accepted read: rd_acc = read_en && !empty.
- Accepted write: wr_acc = write_en && (!full || rd_acc). A write into a full FIFO is accepted only if a read is accepted in the same cycle.
- When empty, a simultaneous read and write: the read is rejected (underflow set) and the write is accepted. There is no bypass.
- count_next = count + wr_acc − rd_acc. Flags are combinational decodes of registered count, so they update the cycle after the causing edge.
- overflow sets when write_en && !wr_acc; underflow sets when read_en && !rd_acc. Both are cleared only by reset. Rejected operations change no other state.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[read_ptr] and data_valid <= 1. Otherwise data_valid <= 0 and data_out holds its value.
  - Read latency is 1 cycle from the edge that samples read_en.
- FWFT mode (FWFT=1):
  - data_out = mem[read_ptr], combinational from registered state. It is valid whenever !empty.
  - data_valid = !empty. read_en pops the head.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
  - The data_out value while empty is don't-care.
- Read-during-write to the same address cannot happen, because the read is gated by empty. No memory forwarding is required.
- The thresholds are elaborated constants. Out-of-range parameter values are an elaboration error, checked with assertions in simulation.

Test Plan:
1. Reset, then 8 writes of 0x10..0x17 followed by 8 reads (FWFT=0) -> data_out 0x10..0x17 in order, each 1 cycle after its read edge with data_valid pulsed; count rises 0→8 then falls back to 0; empty=1 at end; no error flags.
2. DEPTH=32, 33 writes with no reads -> full=1 and count=32 after write 32. Write 33 is rejected and overflow=1 (sticky). Reading all 32 returns the first 32 values.
3. FIFO full, with read_en=1 and write_en=1 in one cycle -> both accepted, count stays 32, overflow stays 0, and the new word is read last.
4. Empty FIFO, read_en=1 -> underflow=1, count=0, data_valid=0. Then read_en=1 and write_en=1 together with 0xAB -> count=1, underflow remains set.
5. Run 100 write/read pairs so both pointers wrap 3+ times -> data order preserved. almost_full asserts at count 28 and almost_empty deasserts at count 5 (defaults).
6. FWFT=1: write 0x55 -> data_out=0x55 and data_valid=1 on the next cycle. Pulse read_en -> empty=1. Then assert reset mid-stream at count=5 -> count=0, flags cleared, data_valid=0.
